plab3_mem_line_word_adapter: RTL and testbench

- Memory-side stage directly downstream of the blocking cache. Consumes the cache's 128-bit cacheline memory requests: refills (read) and evictions (write).
- Splits each line request into four 32-bit word transactions to a word-wide main memory port.
- Reassembles word responses into one 128-bit line response for the cache. The cache then sees a line-wide memory.

---
 rtl/plab3_mem_line_word_adapter_pkg.sv | 29 ++
 rtl/plab3_mem_line_word_adapter_ctrl.sv | 97 +++++++++
 rtl/plab3_mem_line_word_adapter.sv | 112 +++++++++++
 tb/tb_plab3_mem_line_word_adapter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plab3_mem_line_word_adapter_pkg.sv
// ============================================================================
// Module   : plab3_mem_line_word_adapter_pkg
// Brief    : Shared constants for the line-to-word memory adapter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package plab3_mem_line_word_adapter_pkg;

    localparam int         c_TYPE_NBITS      = 3;
    localparam int         c_TEST_NBITS      = 2;
    localparam logic [2:0] c_MSG_READ        = 3'd0;
    localparam logic [2:0] c_MSG_WRITE       = 3'd1;

    localparam int         c_WORDS_PER_LINE  = 4;
    localparam logic [2:0] c_CNT_FULL        = 3'd4;
    localparam logic [2:0] c_CNT_LAST        = 3'd3;

    typedef logic [1:0] state_t;
    localparam state_t c_STATE_IDLE = 2'd0;
    localparam state_t c_STATE_XFER = 2'd1;
    localparam state_t c_STATE_RESP = 2'd2;

endpackage

// Word address inside a 16-byte line: keep the line base, insert the word index.
`define PLAB3_MLWA_WORD_ADDR(base, idx) {base[$bits(base)-1:4], idx, 2'b00}

`default_nettype wire

// File: rtl/plab3_mem_line_word_adapter_ctrl.sv
// ============================================================================
// Module   : plab3_mem_line_word_adapter_ctrl
// Brief    : FSM and send/receive word counters for the line-word adapter.
// Config   : PLAB3_MEM_LINE_WORD_ADAPTER_PIPELINE_EN (multiple outstanding words)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module plab3_mem_line_word_adapter_ctrl
    import plab3_mem_line_word_adapter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_linereq_val,
    output logic       o_linereq_rdy,
    output logic       o_linereq_go,
    output logic       o_wordreq_val,
    input  logic       i_wordreq_rdy,
    input  logic       i_wordresp_val,
    output logic       o_wordresp_rdy,
    output logic       o_wordresp_go,
    output logic       o_lineresp_val,
    input  logic       i_lineresp_rdy,
    output logic [2:0] o_send_cnt,
    output logic [2:0] o_recv_cnt
);

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_send_cnt;
    logic [2:0] r_recv_cnt;
    logic       w_wordreq_go;
    logic       w_lineresp_go;

    assign o_linereq_go  = i_linereq_val && o_linereq_rdy;
    assign w_wordreq_go  = o_wordreq_val && i_wordreq_rdy;
    assign o_wordresp_go = i_wordresp_val && o_wordresp_rdy;
    assign w_lineresp_go = o_lineresp_val && i_lineresp_rdy;
    assign o_send_cnt    = r_send_cnt;
    assign o_recv_cnt    = r_recv_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_STATE_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_STATE_IDLE: if (o_linereq_go) w_state_next = c_STATE_XFER;
            c_STATE_XFER: if (o_wordresp_go && (r_recv_cnt == c_CNT_LAST)) w_state_next = c_STATE_RESP;
            c_STATE_RESP: if (w_lineresp_go) w_state_next = c_STATE_IDLE;
            default:      w_state_next = c_STATE_IDLE;
        endcase
    end

    always_comb begin
        o_linereq_rdy  = 1'b0;
        o_wordreq_val  = 1'b0;
        o_wordresp_rdy = 1'b0;
        o_lineresp_val = 1'b0;
        case (r_state)
            // Gated by rst_n so the cache sees rdy low for the whole reset pulse.
            c_STATE_IDLE: o_linereq_rdy = rst_n;
            c_STATE_XFER: begin
`ifdef PLAB3_MEM_LINE_WORD_ADAPTER_PIPELINE_EN
                o_wordreq_val  = (r_send_cnt < c_CNT_FULL);
`else
                o_wordreq_val  = (r_send_cnt < c_CNT_FULL) && (r_recv_cnt == r_send_cnt);
`endif
                o_wordresp_rdy = (r_recv_cnt < r_send_cnt);
            end
            c_STATE_RESP: o_lineresp_val = 1'b1;
            default: ;
        endcase
    end

    // Counters saturate at a full line; they are cleared when a new line is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_send_cnt <= 3'd0;
            r_recv_cnt <= 3'd0;
        end else if (o_linereq_go) begin
            r_send_cnt <= 3'd0;
            r_recv_cnt <= 3'd0;
        end else begin
            if (w_wordreq_go && (r_send_cnt < c_CNT_FULL)) r_send_cnt <= r_send_cnt + 3'd1;
            if (o_wordresp_go && (r_recv_cnt < c_CNT_FULL)) r_recv_cnt <= r_recv_cnt + 3'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/plab3_mem_line_word_adapter.sv
// ============================================================================
// Module   : plab3_mem_line_word_adapter
// Brief    : Splits 128-bit cacheline requests into 32-bit word transactions
//            and reassembles the word responses into a line response.
// Config   : PLAB3_MEM_LINE_WORD_ADAPTER_PIPELINE_EN (multiple outstanding words)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module plab3_mem_line_word_adapter
    import plab3_mem_line_word_adapter_pkg::*;
#(
    parameter int OPAQUE_NBITS = 8,
    parameter int ABW          = 32,
    parameter int DBW          = 32,
    parameter int CLW          = 128
)(
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                sd,
    input  logic                                                linereq_val,
    output logic                                                linereq_rdy,
    input  logic [3+OPAQUE_NBITS+ABW+$clog2(CLW/8)+CLW-1:0]     linereq_msg,
    output logic                                                lineresp_val,
    input  logic                                                lineresp_rdy,
    output logic [3+OPAQUE_NBITS+2+$clog2(CLW/8)+CLW-1:0]       lineresp_msg,
    output logic                                                wordreq_val,
    input  logic                                                wordreq_rdy,
    output logic [3+OPAQUE_NBITS+ABW+$clog2(DBW/8)+DBW-1:0]     wordreq_msg,
    input  logic                                                wordresp_val,
    output logic                                                wordresp_rdy,
    input  logic [3+OPAQUE_NBITS+2+$clog2(DBW/8)+DBW-1:0]       wordresp_msg
);

    localparam int c_LLEN       = $clog2(CLW/8);
    localparam int c_WLEN       = $clog2(DBW/8);
    localparam int c_ADDR_LSB   = CLW + c_LLEN;
    localparam int c_OPAQUE_LSB = c_ADDR_LSB + ABW;
    localparam int c_TYPE_LSB   = c_OPAQUE_LSB + OPAQUE_NBITS;

    logic [c_TYPE_NBITS-1:0] r_type;
    logic [OPAQUE_NBITS-1:0] r_opaque;
    logic [ABW-1:0]          r_addr;
    logic [CLW-1:0]          r_data;
    logic [CLW-1:0]          r_line;

    logic       w_linereq_go;
    logic       w_wordresp_go;
    logic [2:0] w_send_cnt;
    logic [2:0] w_recv_cnt;
    logic [1:0] w_word_idx;
    logic       w_is_read;
    logic [DBW-1:0] w_wordreq_data;
    logic [CLW-1:0] w_lineresp_data;

    plab3_mem_line_word_adapter_ctrl u_ctrl (
        .clk            (clk),
        .rst_n          (reset),
        .i_linereq_val  (linereq_val),
        .o_linereq_rdy  (linereq_rdy),
        .o_linereq_go   (w_linereq_go),
        .o_wordreq_val  (wordreq_val),
        .i_wordreq_rdy  (wordreq_rdy),
        .i_wordresp_val (wordresp_val),
        .o_wordresp_rdy (wordresp_rdy),
        .o_wordresp_go  (w_wordresp_go),
        .o_lineresp_val (lineresp_val),
        .i_lineresp_rdy (lineresp_rdy),
        .o_send_cnt     (w_send_cnt),
        .o_recv_cnt     (w_recv_cnt)
    );

    // Anything that is not a read (write, init, ...) moves data toward memory.
    assign w_is_read = (r_type == c_MSG_READ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_type   <= '0;
            r_opaque <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_line   <= '0;
        end else if (w_linereq_go) begin
            r_type   <= linereq_msg[c_TYPE_LSB +: c_TYPE_NBITS];
            r_opaque <= linereq_msg[c_OPAQUE_LSB +: OPAQUE_NBITS];
            r_addr   <= linereq_msg[c_ADDR_LSB +: ABW];
            r_data   <= linereq_msg[CLW-1:0];
            r_line   <= '0;
        end else if (w_wordresp_go && w_is_read) begin
            r_line[int'(w_recv_cnt[1:0])*DBW +: DBW] <= wordresp_msg[DBW-1:0];
        end
    end

    assign w_word_idx      = w_send_cnt[1:0];
    assign w_wordreq_data  = w_is_read ? {DBW{1'b0}} : r_data[int'(w_word_idx)*DBW +: DBW];
    assign w_lineresp_data = w_is_read ? r_line : {CLW{1'b0}};

    assign wordreq_msg = {r_type,
                          OPAQUE_NBITS'(w_send_cnt),
                          `PLAB3_MLWA_WORD_ADDR(r_addr, w_word_idx),
                          {c_WLEN{1'b0}},
                          w_wordreq_data};

    assign lineresp_msg = {r_type,
                           r_opaque,
                           {c_TEST_NBITS{1'b0}},
                           {c_LLEN{1'b0}},
                           w_lineresp_data};

endmodule

`default_nettype wire

// File: tb/tb_plab3_mem_line_word_adapter.sv
// ============================================================================
// Module   : tb_plab3_mem_line_word_adapter
// Brief    : Scoreboard bench for the line-word adapter with a word memory model.
// Config   : PLAB3_MEM_LINE_WORD_ADAPTER_PIPELINE_EN (changes outstanding-word limit)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_plab3_mem_line_word_adapter;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         sd = 1'b0;
    logic         linereq_val = 1'b0;
    logic         linereq_rdy;
    logic [174:0] linereq_msg = '0;
    logic         lineresp_val;
    logic         lineresp_rdy = 1'b0;
    logic [144:0] lineresp_msg;
    logic         wordreq_val;
    logic         wordreq_rdy = 1'b0;
    logic [76:0]  wordreq_msg;
    logic         wordresp_val = 1'b0;
    logic         wordresp_rdy;
    logic [46:0]  wordresp_msg = '0;

    plab3_mem_line_word_adapter dut (
        .clk          (clk),
        .reset        (reset),
        .sd           (sd),
        .linereq_val  (linereq_val),
        .linereq_rdy  (linereq_rdy),
        .linereq_msg  (linereq_msg),
        .lineresp_val (lineresp_val),
        .lineresp_rdy (lineresp_rdy),
        .lineresp_msg (lineresp_msg),
        .wordreq_val  (wordreq_val),
        .wordreq_rdy  (wordreq_rdy),
        .wordreq_msg  (wordreq_msg),
        .wordresp_val (wordresp_val),
        .wordresp_rdy (wordresp_rdy),
        .wordresp_msg (wordresp_msg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // ---------------- reference model ----------------
    logic [31:0]  mem     [logic [31:0]];
    logic [31:0]  ref_mem [logic [31:0]];
    logic [76:0]  exp_wreq [$];
    logic [144:0] exp_lresp [$];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0FFEE11;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    task automatic model_issue(input logic [2:0] t, input logic [7:0] op,
                               input logic [31:0] a, input logic [127:0] d);
        logic [31:0]  base;
        logic [31:0]  wa;
        logic [127:0] line = '0;
        base = a & 32'hFFFF_FFF0;
        for (int i = 0; i < 4; i++) begin
            wa = base + 32'(4 * i);
            if (t == 3'd0) begin
                line[32*i +: 32] = ref_rd(wa);
                exp_wreq.push_back({t, 8'(i), wa, 2'b00, 32'h0});
            end else begin
                ref_mem[wa] = d[32*i +: 32];
                exp_wreq.push_back({t, 8'(i), wa, 2'b00, d[32*i +: 32]});
            end
        end
        exp_lresp.push_back({t, op, 2'b00, 4'h0, (t == 3'd0) ? line : 128'h0});
    endtask

    // ---------------- word memory responder ----------------
    typedef struct { int due; logic [46:0] msg; } pend_t;
    pend_t pend [$];
    int lat = 1, wq_stall = 0, lr_stall = 0, wq_hold = 0, lr_hold = 0;
    bit wq_bp_arm = 0, lr_bp_arm = 0;
    int outstanding = 0, max_out = 0;

    always @(negedge clk) begin
        logic [2:0]  t;
        logic [31:0] a, d;
        if (wq_hold > 0) begin
            wordreq_rdy = 1'b0;
            wq_hold--;
        end else if (wq_bp_arm && wordreq_val && wordreq_msg[73:66] == 8'd2) begin
            wordreq_rdy = 1'b0;
            wq_hold = 2;
            wq_bp_arm = 0;
        end else begin
            wordreq_rdy = ($urandom_range(99) >= wq_stall);
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            wordresp_val = 1'b1;
            wordresp_msg = pend[0].msg;
        end else begin
            wordresp_val = 1'b0;
            wordresp_msg = '0;
        end
        #1;
        if (wordreq_val && wordreq_rdy) begin
            t = wordreq_msg[76:74];
            a = wordreq_msg[65:34];
            d = wordreq_msg[31:0];
            if (t == 3'd0) begin
                d = mem.exists(a) ? mem[a] : init_word(a);
            end else begin
                mem[a] = d;
                d = 32'h0;
            end
            pend.push_back('{due: cyc + lat, msg: {t, wordreq_msg[73:66], 2'b00, 2'b00, d}});
            outstanding++;
            if (outstanding > max_out) max_out = outstanding;
        end
        if (wordresp_val && wordresp_rdy) begin
            void'(pend.pop_front());
            outstanding--;
        end
    end

    always @(negedge clk) begin
        if (lr_hold > 0) begin
            lineresp_rdy = 1'b0;
            lr_hold--;
        end else if (lr_bp_arm && lineresp_val) begin
            lineresp_rdy = 1'b0;
            lr_hold = 4;
            lr_bp_arm = 0;
        end else begin
            lineresp_rdy = ($urandom_range(99) >= lr_stall);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [76:0]  wq_held;
    logic [144:0] lr_held;
    logic [144:0] last_lresp = '0;
    bit wq_chk = 0, lr_chk = 0, busy = 0, rdy_next = 0;
    int n_wreq = 0;
    int lresp_cyc [$];

    always @(negedge clk) begin
        #2;
        if (reset) begin
            if (rdy_next) begin
                chk("lreq_rdy_after_resp", linereq_rdy, 1);
                rdy_next = 0;
            end
            if (busy) chk("lreq_rdy_while_busy", linereq_rdy, 0);
            if (linereq_val && linereq_rdy) busy = 1;

            if (wq_chk) begin
                chk("wreq_hold_val", wordreq_val, 1);
                chk("wreq_hold_msg", wordreq_msg, wq_held);
            end
            wq_chk  = wordreq_val && !wordreq_rdy;
            wq_held = wordreq_msg;
            if (wordreq_val && wordreq_rdy) begin
                n_wreq++;
                if (exp_wreq.size() == 0) fail("wreq_unexpected");
                else chk("wreq_msg", wordreq_msg, exp_wreq.pop_front());
            end

            if (lr_chk) begin
                chk("lresp_hold_val", lineresp_val, 1);
                chk("lresp_hold_msg", lineresp_msg, lr_held);
            end
            lr_chk  = lineresp_val && !lineresp_rdy;
            lr_held = lineresp_msg;
            if (lineresp_val && lineresp_rdy) begin
                if (exp_lresp.size() == 0) fail("lresp_unexpected");
                else chk("lresp_msg", lineresp_msg, exp_lresp.pop_front());
                last_lresp = lineresp_msg;
                lresp_cyc.push_back(cyc);
                busy = 0;
                rdy_next = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    int acc_cycle = 0;

    task automatic flush_env();
        pend.delete();
        outstanding = 0;
        exp_wreq.delete();
        exp_lresp.delete();
        wq_chk = 0; lr_chk = 0; busy = 0; rdy_next = 0;
        wq_hold = 0; lr_hold = 0; wq_bp_arm = 0; lr_bp_arm = 0;
    endtask

    task automatic send_line(input logic [2:0] t, input logic [7:0] op,
                             input logic [31:0] a, input logic [127:0] d);
        int waitc = 0;
        @(negedge clk);
        linereq_val = 1'b1;
        linereq_msg = {t, op, a, 4'h0, d};
        #1;
        while (!linereq_rdy) begin
            waitc++;
            if (waitc > 200) begin
                fail("linereq_accept_timeout");
                linereq_val = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        acc_cycle = cyc;
        model_issue(t, op, a, d);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        linereq_val = 1'b0;
        while (exp_lresp.size() != 0 || exp_wreq.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 400) begin
                fail("line_done_timeout");
                flush_env();
                return;
            end
        end
    endtask

    localparam logic [127:0] c_REFILL = 128'h00000044_00000033_00000022_00000011;

    initial begin
        int start, n, nl, a2;
        logic [2:0] t;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_linereq_rdy", linereq_rdy, 0);
        chk("rst_wordreq_val", wordreq_val, 0);
        chk("rst_lineresp_val", lineresp_val, 0);
        chk("rst_wordresp_rdy", wordresp_rdy, 0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("idle_linereq_rdy", linereq_rdy, 1);

        // Read refill with known memory words
        for (int i = 0; i < 4; i++) begin
            mem[32'h1230 + 32'(4*i)]     = 32'h11 * 32'(i + 1);
            ref_mem[32'h1230 + 32'(4*i)] = 32'h11 * 32'(i + 1);
        end
        send_line(3'd0, 8'h5A, 32'h0000_1230, '0);
        wait_done();
        chk("refill_data", last_lresp[127:0], c_REFILL);
        chk("refill_opaque", last_lresp[141:134], 8'h5A);

        // Eviction
        send_line(3'd1, 8'h11, 32'h0000_2000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        wait_done();
        chk("evict_resp_data", last_lresp[127:0], 128'h0);
        chk("evict_mem_word2", mem[32'h2008], 32'hCCCCCCCC);
        chk("evict_mem_word3", mem[32'h200C], 32'hDDDDDDDD);

        // Backpressure on word 2 and on the line response
        wq_bp_arm = 1;
        lr_bp_arm = 1;
        send_line(3'd0, 8'h33, 32'h0000_1230, '0);
        wait_done();
        chk("bp_refill_data", last_lresp[127:0], c_REFILL);
        chk("bp_stalls_applied", {wq_bp_arm, lr_bp_arm}, 2'b00);

        // Outstanding-word limit with a 3-cycle memory
        lat = 3;
        max_out = 0;
        send_line(3'd0, 8'h44, 32'h0000_4000, '0);
        wait_done();
`ifdef PLAB3_MEM_LINE_WORD_ADAPTER_PIPELINE_EN
        chk("max_outstanding", max_out, 4);
`else
        chk("max_outstanding", max_out, 1);
`endif

        // Asynchronous reset in the middle of a transfer
        start = n_wreq;
        send_line(3'd0, 8'h55, 32'h0000_5000, '0);
        @(negedge clk);
        linereq_val = 1'b0;
        n = 0;
        #3;
        while (n_wreq < start + 2 && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (n_wreq < start + 2) fail("two_words_before_reset");
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_wordreq_val", wordreq_val, 0);
        chk("async_rst_lineresp_val", lineresp_val, 0);
        chk("async_rst_wordresp_rdy", wordresp_rdy, 0);
        chk("async_rst_linereq_rdy", linereq_rdy, 0);
        flush_env();
        #1 reset = 1'b1;
        #1 chk("post_rst_linereq_rdy", linereq_rdy, 1);
        lat = 1;
        send_line(3'd0, 8'h66, 32'h0000_5000, '0);
        wait_done();

        // Back-to-back reads
        nl = lresp_cyc.size();
        send_line(3'd0, 8'h77, 32'h0000_6000, '0);
        send_line(3'd0, 8'h78, 32'h0000_6010, '0);
        a2 = acc_cycle;
        wait_done();
        if (lresp_cyc.size() > nl) chk("b2b_accept_gap", 32'(a2 - lresp_cyc[nl]), 32'd1);
        else fail("b2b_first_resp");

        // Randomized traffic with random latency and stalls
        for (int k = 0; k < 40; k++) begin
            n = int'($urandom_range(9));
            t = (n < 5) ? 3'd0 : (n < 9) ? 3'd1 : 3'd2;
            send_line(t, 8'($urandom),
                      {24'h0, 4'($urandom_range(7)), 4'($urandom_range(15))},
                      {$urandom, $urandom, $urandom, $urandom});
            if ($urandom_range(2) != 0) begin
                wait_done();
                lat      = int'($urandom_range(1, 4));
                wq_stall = int'($urandom_range(0, 30));
                lr_stall = int'($urandom_range(0, 30));
            end
        end
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
